// File: rtl/items_pkg.sv
`default_nettype none
// ============================================================================
// Module  : items_pkg
// Purpose : Shared types and tile-coordinate helpers for the maze item store.
// Rev     : 1.0  initial release
// ============================================================================
package items_pkg;

    localparam int unsigned ROWS_DEFAULT = 36;
    localparam int unsigned COLS_DEFAULT = 28;

    typedef enum logic [1:0] {
        I_NONE      = 2'd0,
        I_DOT       = 2'd1,
        I_ENERGIZER = 2'd2,
        I_FRUIT     = 2'd3
    } item_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READY  = 3'd2,
        S_EAT_RD = 3'd3,
        S_EAT_WR = 3'd4
    } state_t;

    function automatic logic in_maze(input logic [5:0] row, input logic [4:0] col,
                                     input int unsigned rows, input int unsigned cols);
        return (32'(row) < rows) && (32'(col) < cols);
    endfunction

    function automatic int unsigned tile_index(input logic [5:0] row, input logic [4:0] col,
                                               input int unsigned cols);
        return 32'(row) * cols + 32'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/items_ram.sv
`default_nettype none
// ============================================================================
// Module  : items_ram
// Purpose : Tile item memory: read/write port for the FSM, read port for the renderer.
// Rev     : 1.0  initial release
// ============================================================================
module items_ram #(
    parameter int DEPTH = 1008,
    parameter int IW    = 2,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [IW-1:0] i_a_wdata,
    output logic [IW-1:0] o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    output logic [IW-1:0] o_b_rdata
);

    logic [IW-1:0] r_mem [0:DEPTH-1];
    logic [IW-1:0] r_a_rdata;
    logic [IW-1:0] r_b_rdata;

    // Read-first on port A: a same-cycle write does not bypass to the read data.
    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        r_a_rdata <= r_mem[i_a_addr];
    end

    always_ff @(posedge i_clk) begin
        r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/items_store.sv
`default_nettype none
// ============================================================================
// Module  : items_store
// Purpose : Maze item tracker: loads the level map from ROM, serves eat
//           requests, feeds the renderer and flags level clear.
// Rev     : 1.0  initial release
// ============================================================================
module items_store
    import items_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT,
    parameter int IW   = 2,
    parameter int AW   = $clog2(ROWS * COLS),
    parameter int CW   = $clog2(ROWS * COLS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_reload,
    output logic [AW-1:0] o_map_addr,
    input  logic [IW-1:0] i_map_data,
    output logic          o_busy,
    input  logic          i_eat_valid,
    output logic          o_eat_ready,
    input  logic [5:0]    i_eat_row,
    input  logic [4:0]    i_eat_col,
    output logic          o_eat_done,
    output logic [IW-1:0] o_eat_type,
    input  logic [5:0]    i_rd_row,
    input  logic [4:0]    i_rd_col,
    output logic [IW-1:0] o_rd_item,
    output logic [CW-1:0] o_dots_left,
    output logic [CW-1:0] o_dots_eaten,
    output logic [CW-1:0] o_energizers_eaten,
    output logic          o_level_clear
);

    localparam int unsigned   c_tiles     = ROWS * COLS;
    localparam logic [AW-1:0] c_last_addr = AW'(c_tiles - 1);
    localparam logic [AW-1:0] c_addr_one  = AW'(1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [CW-1:0] c_load_end  = CW'(c_tiles);

    state_t        r_state;
    logic [AW-1:0] r_map_addr;
    logic [CW-1:0] r_load_cnt;
    logic [CW-1:0] r_dots_left;
    logic [CW-1:0] r_dots_eaten;
    logic [CW-1:0] r_energizers_eaten;
    logic [AW-1:0] r_eat_addr;
    logic          r_eat_oob;
    logic          r_load_clear;
    logic          r_rd_mask;

    logic          w_accept;
    logic          w_eat_fire;
    logic          w_load_wr;
    logic          w_load_dot;
    logic          w_eat_in;
    logic [AW-1:0] w_eat_addr;
    logic          w_rd_in;
    logic [AW-1:0] w_rd_addr;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_a_addr;
    logic [IW-1:0] w_ram_wdata;
    logic [IW-1:0] w_ram_a_rdata;
    logic [IW-1:0] w_ram_b_rdata;
    item_t         w_old;

    always_comb begin
        w_eat_in   = in_maze(i_eat_row, i_eat_col, ROWS, COLS);
        w_eat_addr = w_eat_in ? AW'(tile_index(i_eat_row, i_eat_col, COLS)) : '0;
        w_rd_in    = in_maze(i_rd_row, i_rd_col, ROWS, COLS);
        w_rd_addr  = w_rd_in ? AW'(tile_index(i_rd_row, i_rd_col, COLS)) : '0;

        w_accept   = (r_state == S_READY) && i_eat_valid && !i_reload;
        // Reload or reset in the write cycle drops the eat entirely.
        w_eat_fire = (r_state == S_EAT_WR) && !i_reload && !i_rst;
        // ROM data trails the address by a cycle, so count 0 has nothing to write.
        w_load_wr  = (r_state == S_LOAD) && (r_load_cnt != '0) && !i_reload && !i_rst;
        w_load_dot = w_load_wr && (item_t'(i_map_data) == I_DOT);

        w_old      = r_eat_oob ? I_NONE : item_t'(w_ram_a_rdata);

        w_ram_we     = w_load_wr || (w_eat_fire && !r_eat_oob);
        w_ram_a_addr = (r_state == S_LOAD) ? AW'(r_load_cnt - c_cnt_one) : r_eat_addr;
        w_ram_wdata  = (r_state == S_LOAD) ? i_map_data : IW'(I_NONE);
    end

    items_ram #(
        .DEPTH (c_tiles),
        .IW    (IW),
        .AW    (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_a_we    (w_ram_we),
        .i_a_addr  (w_ram_a_addr),
        .i_a_wdata (w_ram_wdata),
        .o_a_rdata (w_ram_a_rdata),
        .i_b_addr  (w_rd_addr),
        .o_b_rdata (w_ram_b_rdata)
    );

    always_ff @(posedge i_clk) begin
        r_load_clear <= 1'b0;
        if (i_rst) begin
            r_state            <= S_IDLE;
            r_map_addr         <= '0;
            r_load_cnt         <= '0;
            r_dots_left        <= '0;
            r_dots_eaten       <= '0;
            r_energizers_eaten <= '0;
            r_eat_addr         <= '0;
            r_eat_oob          <= 1'b0;
        end else if (i_reload) begin
            r_state            <= S_LOAD;
            r_map_addr         <= '0;
            r_load_cnt         <= '0;
            r_dots_left        <= '0;
            r_dots_eaten       <= '0;
            r_energizers_eaten <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (r_map_addr != c_last_addr) begin
                        r_map_addr <= r_map_addr + c_addr_one;
                    end
                    if (w_load_dot) begin
                        r_dots_left <= r_dots_left + c_cnt_one;
                    end
                    if (r_load_cnt == c_load_end) begin
                        r_state      <= S_READY;
                        r_load_clear <= (r_dots_left == '0) && !w_load_dot;
                    end else begin
                        r_load_cnt <= r_load_cnt + c_cnt_one;
                    end
                end
                S_READY: begin
                    if (w_accept) begin
                        r_state    <= S_EAT_RD;
                        r_eat_addr <= w_eat_addr;
                        r_eat_oob  <= !w_eat_in;
                    end
                end
                S_EAT_RD: begin
                    r_state <= S_EAT_WR;
                end
                S_EAT_WR: begin
                    case (w_old)
                        I_DOT: begin
                            r_dots_left  <= r_dots_left - c_cnt_one;
                            r_dots_eaten <= r_dots_eaten + c_cnt_one;
                        end
                        I_ENERGIZER: begin
                            r_energizers_eaten <= r_energizers_eaten + c_cnt_one;
                        end
                        default: begin
                        end
                    endcase
                    r_state <= S_READY;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Renderer data is hidden if the request was out of range or issued mid-load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_mask <= 1'b1;
        end else begin
            r_rd_mask <= !w_rd_in || (r_state == S_LOAD);
        end
    end

    assign o_map_addr         = r_map_addr;
    assign o_busy             = (r_state == S_LOAD);
    assign o_eat_ready        = (r_state == S_READY) && !i_reload;
    assign o_eat_done         = w_eat_fire;
    assign o_eat_type         = w_eat_fire ? IW'(w_old) : IW'(I_NONE);
    assign o_rd_item          = (r_rd_mask || o_busy) ? IW'(I_NONE) : w_ram_b_rdata;
    assign o_dots_left        = r_dots_left;
    assign o_dots_eaten       = r_dots_eaten;
    assign o_energizers_eaten = r_energizers_eaten;
    assign o_level_clear      = r_load_clear ||
                                (w_eat_fire && (w_old == I_DOT) && (r_dots_left == c_cnt_one));

    a_no_dot_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_eat_fire && (w_old == I_DOT) && (r_dots_left == '0)));

endmodule
`default_nettype wire

// File: tb/tb_items_store.sv
`default_nettype none
// ============================================================================
// Module  : tb_items_store
// Purpose : Randomised scoreboard bench for items_store on a 4x4 maze.
// Rev     : 1.0  initial release
// ============================================================================
module tb_items_store;
    import items_pkg::*;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          reload;
    logic [AW-1:0] map_addr;
    logic [1:0]    map_data = 2'd0;
    logic          busy;
    logic          eat_valid;
    logic          eat_ready;
    logic [5:0]    eat_row;
    logic [4:0]    eat_col;
    logic          eat_done;
    logic [1:0]    eat_type;
    logic [5:0]    rd_row;
    logic [4:0]    rd_col;
    logic [1:0]    rd_item;
    logic [CW-1:0] dots_left;
    logic [CW-1:0] dots_eaten;
    logic [CW-1:0] en_eaten;
    logic          level_clear;

    always #5 clk = ~clk;

    items_store #(.ROWS(R), .COLS(C), .IW(2)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_reload           (reload),
        .o_map_addr         (map_addr),
        .i_map_data         (map_data),
        .o_busy             (busy),
        .i_eat_valid        (eat_valid),
        .o_eat_ready        (eat_ready),
        .i_eat_row          (eat_row),
        .i_eat_col          (eat_col),
        .o_eat_done         (eat_done),
        .o_eat_type         (eat_type),
        .i_rd_row           (rd_row),
        .i_rd_col           (rd_col),
        .o_rd_item          (rd_item),
        .o_dots_left        (dots_left),
        .o_dots_eaten       (dots_eaten),
        .o_energizers_eaten (en_eaten),
        .o_level_clear      (level_clear)
    );

    // Map ROM: one cycle read latency.
    logic [1:0] rom [N];
    always @(posedge clk) map_data <= rom[map_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int typ;
        int lc;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   mdl [N];
    int   m_left, m_eaten, m_en;
    int   lc_count, lc_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_dots_left"}, int'(dots_left), m_left);
        chk({tag, "_dots_eaten"}, int'(dots_eaten), m_eaten);
        chk({tag, "_energizers_eaten"}, int'(en_eaten), m_en);
    endtask

    // Scoreboard monitor
    exp_t me;
    always @(negedge clk) begin
        if (level_clear) lc_count++;
        if (!rst && eat_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                me = sb.pop_front();
                chk("eat_type", int'(eat_type), me.typ);
                chk("eat_latency", cyc - me.acc, 2);
                chk("eat_level_clear", int'(level_clear), me.lc);
            end
        end
    end

    task automatic do_reload();
        int n;
        int dots;
        rd_row = 6'd0;
        rd_col = 5'd0;
        reload = 1'b1;
        step();
        reload = 1'b0;
        sb.delete();
        lc_count = 0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 5) chk("rd_masked_while_busy", int'(rd_item), 0);
            n++;
            step();
        end
        chk("load_busy_cycles", n, N + 1);
        dots = 0;
        for (int i = 0; i < N; i++) begin
            mdl[i] = int'(rom[i]);
            if (mdl[i] == 1) dots++;
        end
        m_left  = dots;
        m_eaten = 0;
        m_en    = 0;
        lc_exp  = (dots == 0) ? 1 : 0;
        chk("load_level_clear", int'(level_clear), lc_exp);
        chk_counters("load");
    endtask

    task automatic eat(input int row, input int col, input bit drop);
        int   n;
        int   idx;
        bit   inr;
        exp_t e;
        eat_valid = 1'b1;
        eat_row   = 6'(row);
        eat_col   = 5'(col);
        n = 0;
        while (!eat_ready && n < 50) begin
            n++;
            step();
        end
        if (!eat_ready) begin
            chk("eat_ready_timeout", 0, 1);
            eat_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        step();
        eat_valid = 1'b0;
        if (drop) return;
        inr   = (row < R) && (col < C);
        idx   = row * C + col;
        e.typ = inr ? mdl[idx] : 0;
        e.lc  = 0;
        if (inr) mdl[idx] = 0;
        if (e.typ == 1) begin
            m_left--;
            m_eaten++;
            e.lc = (m_left == 0) ? 1 : 0;
        end
        if (e.typ == 2) m_en++;
        if (e.lc != 0) lc_exp++;
        sb.push_back(e);
        step();
        step();
        chk("eat_sb_drained", sb.size(), 0);
        chk_counters("eat");
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            rd_row = 6'(i / C);
            rd_col = 5'(i % C);
            step();
            chk("rd_tile", int'(rd_item), mdl[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) rom[i] = 2'd0;
        rom[0] = 2'd1; rom[1] = 2'd1; rom[2] = 2'd1; rom[5] = 2'd2;
        rst = 1'b1; reload = 1'b0; eat_valid = 1'b0;
        eat_row = '0; eat_col = '0; rd_row = '0; rd_col = '0;
        m_left = 0; m_eaten = 0; m_en = 0; lc_count = 0; lc_exp = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(eat_ready), 0);
        chk("rst_done", int'(eat_done), 0);
        chk("rst_map_addr", int'(map_addr), 0);
        chk("rst_rd_item", int'(rd_item), 0);
        chk("rst_level_clear", int'(level_clear), 0);
        chk_counters("rst");

        // Directed map load and eats
        do_reload();
        eat(0, 1, 1'b0);
        eat(0, 1, 1'b0);
        eat(1, 1, 1'b0);
        eat(0, 0, 1'b0);
        eat(0, 2, 1'b0);
        step();
        chk("s3_level_clear_once", lc_count, 1);
        eat(4, 0, 1'b0);
        check_all();

        // Reload while an eat sits in its read cycle
        eat(0, 0, 1'b1);
        do_reload();
        chk("s5_sb_empty", sb.size(), 0);
        check_all();

        // Reset in the middle of a load
        reload = 1'b1;
        step();
        reload = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_left = 0; m_eaten = 0; m_en = 0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(eat_ready), 0);
        chk("midrst_map_addr", int'(map_addr), 0);
        chk("midrst_rd_item", int'(rd_item), 0);
        chk_counters("midrst");

        // Dot-free map must flag level clear as the load finishes
        for (int i = 0; i < N; i++) rom[i] = 2'd0;
        rom[3] = 2'd2; rom[9] = 2'd3;
        do_reload();
        eat(2, 1, 1'b0);
        eat(0, 3, 1'b0);
        step();
        chk("zero_dot_lc_count", lc_count, 1);

        // Random maps with random eats, including off-maze coordinates
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) rom[i] = 2'($urandom_range(0, 3));
            do_reload();
            rd_row = 6'(R);
            rd_col = 5'($urandom_range(0, C - 1));
            step();
            chk("rd_out_of_range", int'(rd_item), 0);
            check_all();
            for (int k = 0; k < 24; k++) begin
                eat(int'($urandom_range(0, R)), int'($urandom_range(0, C)), 1'b0);
            end
            check_all();
            step();
            chk("rand_level_clear_count", lc_count, lc_exp);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
